param_regfile: RTL and testbench

//  Responder side of the accelerator's parameter-storage interface. Holds the recursion-parameter list
//  (InexRecur: 32b {i,z,k,l}) and the per-entry execution state (18b).

---
 rtl/param_rf_pkg.sv | 22 ++
 rtl/param_rf_bank.sv | 47 ++++
 rtl/param_regfile.sv | 133 +++++++++++++
 tb/tb_param_regfile.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/param_rf_pkg.sv
// Shared constants and payload types for the parameter register file.
// Build option PARAM_REGFILE_BYPASS_EN selects write-first read behaviour.
package param_rf_pkg;

    localparam int unsigned AW_DEF    = 12;
    localparam int unsigned DW_IR_DEF = 32;
    localparam int unsigned DW_ST_DEF = 18;
    localparam int unsigned DEPTH_DEF = 4096;

    // InexRecur entry: i in the top byte, then z, k, l.
    typedef struct packed {
        logic [7:0] i;
        logic [7:0] z;
        logic [7:0] k;
        logic [7:0] l;
    } ir_t;

    function automatic int unsigned idx_w(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/param_rf_bank.sv
// Storage bank with an append port, a random write port and one read port.
// PARAM_REGFILE_BYPASS_EN forwards same-cycle write data to the read port.
module param_rf_bank
    import param_rf_pkg::*;
#(
    parameter int unsigned W     = 32,
    parameter int unsigned DEPTH = 4096,
    parameter int unsigned AW    = 12
) (
    input  logic          clk,
    input  logic          app_we,
    input  logic [AW-1:0] app_addr,
    input  logic [W-1:0]  app_data,
    input  logic          ran_we,
    input  logic [AW-1:0] ran_addr,
    input  logic [W-1:0]  ran_data,
    input  logic [AW-1:0] rd_addr,
    output logic [W-1:0]  rd_data_c
);

    localparam int unsigned IW = idx_w(DEPTH);

    logic [W-1:0] mem [DEPTH];

    // Callers guarantee both write addresses are in range and never equal.
    always_ff @(posedge clk) begin
        if (app_we) begin
            mem[IW'(app_addr)] <= app_data;
        end
        if (ran_we) begin
            mem[IW'(ran_addr)] <= ran_data;
        end
    end

    always_comb begin
        rd_data_c = mem[IW'(rd_addr)];
`ifdef PARAM_REGFILE_BYPASS_EN
        if (app_we && (app_addr == rd_addr)) begin
            rd_data_c = app_data;
        end
        if (ran_we && (ran_addr == rd_addr)) begin
            rd_data_c = ran_data;
        end
`endif
    end

endmodule

// File: rtl/param_regfile.sv
// Parameter-storage responder: InexRecur and state files sharing one index/tail.
// Read/write collision behaviour follows build option PARAM_REGFILE_BYPASS_EN.
module param_regfile #(
    parameter int unsigned DEPTH = param_rf_pkg::DEPTH_DEF,
    parameter int unsigned AW    = param_rf_pkg::AW_DEF,
    parameter int unsigned DW_IR = param_rf_pkg::DW_IR_DEF,
    parameter int unsigned DW_ST = param_rf_pkg::DW_ST_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             re_seq_i,
    input  logic             re_ran_i,
    input  logic [AW-1:0]    r_addr_i,
    output logic [AW-1:0]    rd_addr_o,
    output logic [DW_IR-1:0] rd_InexRecur_o,
    output logic [DW_ST-1:0] rd_state_o,
    output logic             rd_valid_o,
    input  logic             seq_we_i,
    input  logic [DW_IR-1:0] seq_w_InexRecur_i,
    input  logic [DW_ST-1:0] seq_w_state_i,
    input  logic             ran_we_state_i,
    input  logic             ran_we_InexRecur_i,
    input  logic [AW-1:0]    ran_w_addr_i,
    input  logic [DW_ST-1:0] ran_w_state_i,
    input  logic [DW_IR-1:0] ran_w_InexRecur_i,
    output logic [AW:0]      count_o,
    output logic             overflow_o
);

    import param_rf_pkg::*;

    localparam int unsigned CW = AW + 1;

    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      tail;

    logic             full_c;
    logic             app_we_c;
    logic             ran_in_range_c;
    logic             ir_we_c;
    logic             st_we_c;
    logic             seq_rd_c;
    logic [AW-1:0]    rd_sel_c;
    logic             hit_c;
    logic [AW:0]      ptr_inc_c;
    logic [AW-1:0]    ptr_next_c;
    logic [DW_IR-1:0] ir_data_c;
    logic [DW_ST-1:0] st_data_c;

    // Write qualification; writes are suppressed while reset is held.
    always_comb begin
        full_c         = (tail == CW'(DEPTH));
        app_we_c       = seq_we_i & ~full_c & ~rst;
        ran_in_range_c = ({1'b0, ran_w_addr_i} < tail);
        ir_we_c        = ran_we_InexRecur_i & ran_in_range_c & ~rst;
        st_we_c        = ran_we_state_i & ran_in_range_c & ~rst;
    end

    // Read arbitration: random wins; sequential wrap uses the pre-append tail.
    always_comb begin
        seq_rd_c   = re_seq_i & ~re_ran_i;
        rd_sel_c   = re_ran_i ? r_addr_i : rd_ptr;
        ptr_inc_c  = {1'b0, rd_ptr} + CW'(1);
        ptr_next_c = (ptr_inc_c == tail) ? '0 : AW'(ptr_inc_c);
        if (re_ran_i) begin
            hit_c = ({1'b0, r_addr_i} < tail);
`ifdef PARAM_REGFILE_BYPASS_EN
            if (app_we_c && ({1'b0, r_addr_i} == tail)) begin
                hit_c = 1'b1;
            end
`endif
        end else begin
            hit_c = (tail != '0);
        end
    end

    param_rf_bank #(.W(DW_IR), .DEPTH(DEPTH), .AW(AW)) u_ir_bank (
        .clk       (clk),
        .app_we    (app_we_c),
        .app_addr  (AW'(tail)),
        .app_data  (seq_w_InexRecur_i),
        .ran_we    (ir_we_c),
        .ran_addr  (ran_w_addr_i),
        .ran_data  (ran_w_InexRecur_i),
        .rd_addr   (rd_sel_c),
        .rd_data_c (ir_data_c)
    );

    param_rf_bank #(.W(DW_ST), .DEPTH(DEPTH), .AW(AW)) u_st_bank (
        .clk       (clk),
        .app_we    (app_we_c),
        .app_addr  (AW'(tail)),
        .app_data  (seq_w_state_i),
        .ran_we    (st_we_c),
        .ran_addr  (ran_w_addr_i),
        .ran_data  (ran_w_state_i),
        .rd_addr   (rd_sel_c),
        .rd_data_c (st_data_c)
    );

    // Pointers, sticky overflow and the registered read port.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr         <= '0;
            tail           <= '0;
            overflow_o     <= 1'b0;
            rd_addr_o      <= '0;
            rd_InexRecur_o <= '0;
            rd_state_o     <= '0;
            rd_valid_o     <= 1'b0;
        end else begin
            if (app_we_c) begin
                tail <= tail + CW'(1);
            end
            if (seq_we_i && full_c) begin
                overflow_o <= 1'b1;
            end
            if (seq_rd_c && (tail != '0)) begin
                rd_ptr <= ptr_next_c;
            end
            rd_valid_o <= 1'b0;
            if (re_ran_i || re_seq_i) begin
                rd_addr_o      <= rd_sel_c;
                rd_valid_o     <= hit_c;
                rd_InexRecur_o <= hit_c ? ir_data_c : '0;
                rd_state_o     <= hit_c ? st_data_c : '0;
            end
        end
    end

    assign count_o = tail;

endmodule

// File: tb/tb_param_regfile.sv
// Directed bench for param_regfile in a DEPTH=4 build.
// Collision expectations follow PARAM_REGFILE_BYPASS_EN.
module tb_param_regfile;

    localparam int unsigned AW    = 12;
    localparam int unsigned DW_IR = 32;
    localparam int unsigned DW_ST = 18;
    localparam int unsigned DEPTH = 4;

    localparam logic [DW_IR-1:0] IR_A = 32'h0A0B0C0D;
    localparam logic [DW_IR-1:0] IR_B = 32'h1B2B3B4B;
    localparam logic [DW_IR-1:0] IR_C = 32'h2C3C4C5C;
    localparam logic [DW_IR-1:0] IR_D = 32'h3D3D3D3D;
    localparam logic [DW_IR-1:0] IR_E = 32'hEEEEEEEE;
    localparam logic [DW_ST-1:0] ST_A = 18'h00A11;
    localparam logic [DW_ST-1:0] ST_B = 18'h01B22;
    localparam logic [DW_ST-1:0] ST_C = 18'h02C33;
    localparam logic [DW_ST-1:0] ST_D = 18'h03D44;
    localparam logic [DW_ST-1:0] ST_E = 18'h2EE55;

    logic             clk;
    logic             rst;
    logic             re_seq;
    logic             re_ran;
    logic [AW-1:0]    r_addr;
    logic [AW-1:0]    rd_addr;
    logic [DW_IR-1:0] rd_ir;
    logic [DW_ST-1:0] rd_st;
    logic             rd_valid;
    logic             seq_we;
    logic [DW_IR-1:0] seq_ir;
    logic [DW_ST-1:0] seq_st;
    logic             ran_we_st;
    logic             ran_we_ir;
    logic [AW-1:0]    ran_addr;
    logic [DW_ST-1:0] ran_st;
    logic [DW_IR-1:0] ran_ir;
    logic [AW:0]      count;
    logic             overflow;

    int errors = 0;
    int checks = 0;

    param_regfile #(.DEPTH(DEPTH), .AW(AW), .DW_IR(DW_IR), .DW_ST(DW_ST)) dut (
        .clk                (clk),
        .rst                (rst),
        .re_seq_i           (re_seq),
        .re_ran_i           (re_ran),
        .r_addr_i           (r_addr),
        .rd_addr_o          (rd_addr),
        .rd_InexRecur_o     (rd_ir),
        .rd_state_o         (rd_st),
        .rd_valid_o         (rd_valid),
        .seq_we_i           (seq_we),
        .seq_w_InexRecur_i  (seq_ir),
        .seq_w_state_i      (seq_st),
        .ran_we_state_i     (ran_we_st),
        .ran_we_InexRecur_i (ran_we_ir),
        .ran_w_addr_i       (ran_addr),
        .ran_w_state_i      (ran_st),
        .ran_w_InexRecur_i  (ran_ir),
        .count_o            (count),
        .overflow_o         (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1 time unit after a rising edge; outputs are sampled there too.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 1'b0; re_seq = 1'b0; re_ran = 1'b0; r_addr = '0;
        seq_we = 1'b0; seq_ir = '0; seq_st = '0;
        ran_we_st = 1'b0; ran_we_ir = 1'b0; ran_addr = '0; ran_st = '0; ran_ir = '0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic append(input logic [DW_IR-1:0] ir, input logic [DW_ST-1:0] st);
        seq_we = 1'b1; seq_ir = ir; seq_st = st;
        step();
        seq_we = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({rd_addr, rd_ir, rd_st, rd_valid, count, overflow} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got addr=%0h ir=%h st=%h v=%0b cnt=%0d ovf=%0b exp all 0",
                     rd_addr, rd_ir, rd_st, rd_valid, count, overflow);
        end
    endtask

    task automatic test_seq_wrap();
        logic [AW-1:0]    ea [4];
        logic [DW_IR-1:0] ei [4];
        logic [DW_ST-1:0] es [4];
        ea = '{12'd0, 12'd1, 12'd2, 12'd0};
        ei = '{IR_A, IR_B, IR_C, IR_A};
        es = '{ST_A, ST_B, ST_C, ST_A};
        do_reset();
        append(IR_A, ST_A);
        append(IR_B, ST_B);
        append(IR_C, ST_C);
        checks++;
        if (count !== 13'd3) begin
            errors++;
            $display("FAIL seq_count got %0d exp 3", count);
        end
        re_seq = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if ({rd_addr, rd_ir, rd_st, rd_valid} !== {ea[i], ei[i], es[i], 1'b1}) begin
                errors++;
                $display("FAIL seq_read%0d got addr=%0d ir=%h st=%h v=%0b exp addr=%0d ir=%h st=%h v=1",
                         i, rd_addr, rd_ir, rd_st, rd_valid, ea[i], ei[i], es[i]);
            end
        end
        re_seq = 1'b0;
        step();
        checks++;
        if ({rd_addr, rd_ir, rd_st, rd_valid} !== {12'd0, IR_A, ST_A, 1'b0}) begin
            errors++;
            $display("FAIL seq_hold got addr=%0d ir=%h st=%h v=%0b exp addr=0 ir=%h st=%h v=0",
                     rd_addr, rd_ir, rd_st, rd_valid, IR_A, ST_A);
        end
    endtask

    task automatic test_empty();
        do_reset();
        re_seq = 1'b1;
        step();
        re_seq = 1'b0;
        checks++;
        if ({rd_addr, rd_ir, rd_st, rd_valid} !== '0) begin
            errors++;
            $display("FAIL empty_seq got addr=%0d ir=%h st=%h v=%0b exp all 0", rd_addr, rd_ir, rd_st, rd_valid);
        end
        re_ran = 1'b1; r_addr = 12'd5;
        step();
        re_ran = 1'b0;
        checks++;
        if ({rd_addr, rd_ir, rd_st, rd_valid} !== {12'd5, 32'd0, 18'd0, 1'b0}) begin
            errors++;
            $display("FAIL empty_ran got addr=%0d ir=%h st=%h v=%0b exp addr=5 data 0 v=0",
                     rd_addr, rd_ir, rd_st, rd_valid);
        end
        append(IR_B, ST_B);
        re_seq = 1'b1;
        step();
        re_seq = 1'b0;
        checks++;
        if ({rd_addr, rd_ir, rd_valid} !== {12'd0, IR_B, 1'b1}) begin
            errors++;
            $display("FAIL empty_ptr_held got addr=%0d ir=%h v=%0b exp addr=0 ir=%h v=1", rd_addr, rd_ir, rd_valid, IR_B);
        end
    endtask

    task automatic test_priority();
        do_reset();
        append(IR_A, ST_A);
        append(IR_B, ST_B);
        append(IR_C, ST_C);
        re_seq = 1'b1; re_ran = 1'b1; r_addr = 12'd2;
        step();
        re_ran = 1'b0;
        checks++;
        if ({rd_addr, rd_ir, rd_st, rd_valid} !== {12'd2, IR_C, ST_C, 1'b1}) begin
            errors++;
            $display("FAIL prio_ran got addr=%0d ir=%h st=%h v=%0b exp addr=2 ir=%h st=%h v=1",
                     rd_addr, rd_ir, rd_st, rd_valid, IR_C, ST_C);
        end
        step();
        re_seq = 1'b0;
        checks++;
        if ({rd_addr, rd_ir, rd_valid} !== {12'd0, IR_A, 1'b1}) begin
            errors++;
            $display("FAIL prio_seq_next got addr=%0d ir=%h v=%0b exp addr=0 ir=%h v=1", rd_addr, rd_ir, rd_valid, IR_A);
        end
    endtask

    task automatic test_write_collision();
        logic [DW_ST-1:0] exp_st;
        // Tail is 3 with A,B,C from the previous test.
        ran_we_st = 1'b1; ran_addr = 12'd1; ran_st = 18'h3FFFF;
        re_ran = 1'b1; r_addr = 12'd1;
        step();
        ran_we_st = 1'b0;
`ifdef PARAM_REGFILE_BYPASS_EN
        exp_st = 18'h3FFFF;
`else
        exp_st = ST_B;
`endif
        checks++;
        if ({rd_addr, rd_ir, rd_st, rd_valid} !== {12'd1, IR_B, exp_st, 1'b1}) begin
            errors++;
            $display("FAIL rw_same_cycle got addr=%0d ir=%h st=%h v=%0b exp addr=1 ir=%h st=%h v=1",
                     rd_addr, rd_ir, rd_st, rd_valid, IR_B, exp_st);
        end
        step();
        re_ran = 1'b0;
        checks++;
        if ({rd_ir, rd_st, rd_valid} !== {IR_B, 18'h3FFFF, 1'b1}) begin
            errors++;
            $display("FAIL rw_after got ir=%h st=%h v=%0b exp ir=%h st=3ffff v=1", rd_ir, rd_st, rd_valid, IR_B);
        end
        // Out-of-range random write is ignored; in-range IR write lands alongside an append.
        ran_we_ir = 1'b1; ran_addr = 12'd3; ran_ir = IR_E;
        step();
        ran_addr = 12'd0;
        seq_we = 1'b1; seq_ir = IR_D; seq_st = ST_D;
        re_ran = 1'b1; r_addr = 12'd3;
        step();
        seq_we = 1'b0; ran_we_ir = 1'b0;
        checks++;
`ifdef PARAM_REGFILE_BYPASS_EN
        if ({rd_addr, rd_ir, rd_st, rd_valid} !== {12'd3, IR_D, ST_D, 1'b1}) begin
            errors++;
            $display("FAIL append_read got addr=%0d ir=%h st=%h v=%0b exp addr=3 ir=%h st=%h v=1",
                     rd_addr, rd_ir, rd_st, rd_valid, IR_D, ST_D);
        end
`else
        if ({rd_addr, rd_ir, rd_st, rd_valid} !== {12'd3, 32'd0, 18'd0, 1'b0}) begin
            errors++;
            $display("FAIL append_read got addr=%0d ir=%h st=%h v=%0b exp addr=3 data 0 v=0",
                     rd_addr, rd_ir, rd_st, rd_valid);
        end
`endif
        r_addr = 12'd3;
        step();
        checks++;
        if ({rd_ir, rd_st, rd_valid, count} !== {IR_D, ST_D, 1'b1, 13'd4}) begin
            errors++;
            $display("FAIL oor_write_ignored got ir=%h st=%h v=%0b cnt=%0d exp ir=%h st=%h v=1 cnt=4",
                     rd_ir, rd_st, rd_valid, count, IR_D, ST_D);
        end
        r_addr = 12'd0;
        step();
        re_ran = 1'b0;
        checks++;
        if ({rd_ir, rd_st, rd_valid} !== {IR_E, ST_A, 1'b1}) begin
            errors++;
            $display("FAIL ran_ir_write got ir=%h st=%h v=%0b exp ir=%h st=%h v=1", rd_ir, rd_st, rd_valid, IR_E, ST_A);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        append(IR_A, ST_A);
        append(IR_B, ST_B);
        append(IR_C, ST_C);
        append(IR_D, ST_D);
        checks++;
        if ({count, overflow} !== {13'd4, 1'b0}) begin
            errors++;
            $display("FAIL full_no_ovf got cnt=%0d ovf=%0b exp cnt=4 ovf=0", count, overflow);
        end
        append(IR_E, ST_E);
        checks++;
        if ({count, overflow} !== {13'd4, 1'b1}) begin
            errors++;
            $display("FAIL ovf_set got cnt=%0d ovf=%0b exp cnt=4 ovf=1", count, overflow);
        end
        re_ran = 1'b1; r_addr = 12'd3;
        step();
        step();
        re_ran = 1'b0;
        checks++;
        if ({rd_addr, rd_ir, rd_st, rd_valid, overflow} !== {12'd3, IR_D, ST_D, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL ovf_entry3 got addr=%0d ir=%h st=%h v=%0b ovf=%0b exp addr=3 ir=%h st=%h v=1 ovf=1",
                     rd_addr, rd_ir, rd_st, rd_valid, overflow, IR_D, ST_D);
        end
    endtask

    task automatic test_reset_inflight();
        // Overflow is still set from the previous test.
        re_seq = 1'b1;
        step();
        checks++;
        if ({rd_addr, rd_ir, rd_valid} !== {12'd0, IR_A, 1'b1}) begin
            errors++;
            $display("FAIL pre_rst_read got addr=%0d ir=%h v=%0b exp addr=0 ir=%h v=1", rd_addr, rd_ir, rd_valid, IR_A);
        end
        rst = 1'b1;
        step();
        rst = 1'b0; re_seq = 1'b0;
        checks++;
        if ({rd_addr, rd_ir, rd_st, rd_valid, count, overflow} !== '0) begin
            errors++;
            $display("FAIL rst_inflight got addr=%0d ir=%h st=%h v=%0b cnt=%0d ovf=%0b exp all 0",
                     rd_addr, rd_ir, rd_st, rd_valid, count, overflow);
        end
        step();
        checks++;
        if ({rd_valid, count, overflow} !== '0) begin
            errors++;
            $display("FAIL rst_no_pulse got v=%0b cnt=%0d ovf=%0b exp all 0", rd_valid, count, overflow);
        end
    endtask

    initial begin
        idle();
        test_reset();
        test_seq_wrap();
        test_empty();
        test_priority();
        test_write_collision();
        test_overflow();
        test_reset_inflight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
